datapath_sequencer: RTL and testbench



---
 rtl/datapath_sequencer_pkg.sv | 42 ++++
 rtl/datapath_sequencer_if.sv | 27 ++
 rtl/datapath_sequencer_mem_wait_timer.sv | 34 +++
 rtl/datapath_sequencer.sv | 106 ++++++++++
 tb/tb_datapath_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_sequencer_pkg.sv
// Shared processor definitions: sequencer state encodings, opcode constants
// and opcode-class helpers used by the control sequencer.
package proc_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXE    = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  function automatic logic is_mem_read(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_POP);
  endfunction

  function automatic logic is_mem_write(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_PUSH);
  endfunction

  function automatic logic is_sp_op(input logic [5:0] op);
    return (op == OP_PUSH) || (op == OP_POP);
  endfunction

  function automatic logic is_rf_write(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_JAL) ||
           (op == OP_LW)    || (op == OP_POP);
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Sequencer-to-datapath bundle: opcode and memory handshake in, register
// load enables, memory strobes and status out.
interface datapath_sequencer_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [2:0] state;
  logic       ir_load;
  logic       pc_load;
  logic       sp_load;
  logic       rf_write;
  logic       mem_read;
  logic       mem_write;
  logic       halted;
  logic       timeout;

  modport master (
    input  opcode, mem_ready,
    output state, ir_load, pc_load, sp_load, rf_write,
           mem_read, mem_write, halted, timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  state, ir_load, pc_load, sp_load, rf_write,
           mem_read, mem_write, halted, timeout
  );
endinterface

// File: rtl/datapath_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting on the memory handshake and flags the cycle in
// which the wait budget runs out without a ready.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Ready in the final cycle takes priority over expiry.
  assign expired = enable && !ready && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !ready && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through
// fetch/decode/execute/memory/write-back and drives datapath enables.
module datapath_sequencer
  import proc_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  datapath_sequencer_if.master bus
);

  state_t     state;
  state_t     next_state;
  logic [5:0] op;
  logic       mem_access;
  logic       waiting;
  logic       clear_wait;
  logic       expired;

  assign mem_access = is_mem_read(op) || is_mem_write(op);
  // Only FETCH and a memory-op MEM look at the handshake; the timer idles
  // (held clear) everywhere else so it starts from zero on every wait entry.
  assign waiting    = (state == ST_FETCH) || ((state == ST_MEM) && mem_access);
  assign clear_wait = !waiting;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_wait),
    .enable (waiting),
    .ready  (bus.mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: the op register is a single control register, so it gets a reset
  // like any other state; only wide storage arrays would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op <= OP_RTYPE;
    else if (state == ST_DECODE) op <= bus.opcode;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   next_state = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready) next_state = ST_DECODE;
        else if (expired)  next_state = ST_ERROR;
      end
      ST_DECODE: next_state = (bus.opcode == OP_HALT) ? ST_HALT : ST_EXE;
      ST_EXE:    next_state = ST_MEM;
      ST_MEM: begin
        if (!mem_access || bus.mem_ready) next_state = ST_WB;
        else if (expired)                 next_state = ST_ERROR;
      end
      ST_WB:     next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      ST_ERROR:  next_state = ST_ERROR;
    endcase
  end

  assign bus.state = state;

  always_comb begin
    bus.ir_load   = 1'b0;
    bus.pc_load   = 1'b0;
    bus.sp_load   = 1'b0;
    bus.rf_write  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.halted    = 1'b0;
    bus.timeout   = 1'b0;
    unique case (state)
      ST_FETCH: begin
        bus.mem_read = 1'b1;
        bus.ir_load  = bus.mem_ready;
      end
      ST_MEM: begin
        bus.mem_read  = is_mem_read(op);
        bus.mem_write = is_mem_write(op);
        bus.sp_load   = is_sp_op(op) && bus.mem_ready;
      end
      ST_WB: begin
        bus.pc_load  = 1'b1;
        bus.rf_write = is_rf_write(op);
      end
      ST_HALT:  bus.halted = 1'b1;
      ST_ERROR: begin
        bus.halted  = 1'b1;
        bus.timeout = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scenario-driven scoreboard bench for datapath_sequencer: expected output
// vectors are queued as each cycle's stimulus is driven and compared mid-cycle.
module tb_datapath_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pc, sp, rf, mr, mw, hl, to;
  } outv_t;

  typedef struct packed {
    logic [5:0] op;
    logic       rdy;
    outv_t      exp;
  } vec_t;

  localparam logic [7:0] F_IR = 8'h80, F_PC = 8'h40, F_SP = 8'h20, F_RF = 8'h10;
  localparam logic [7:0] F_MR = 8'h08, F_MW = 8'h04, F_HL = 8'h02, F_TO = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t  stim[$];
  outv_t sb[$];
  outv_t got, want;

  datapath_sequencer_if bus ();

  datapath_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic outv_t ev(input logic [2:0] st, input logic [7:0] f);
    outv_t o;
    o = {st, f};
    return o;
  endfunction

  function automatic outv_t sample();
    outv_t o;
    o = {bus.state, bus.ir_load, bus.pc_load, bus.sp_load, bus.rf_write,
         bus.mem_read, bus.mem_write, bus.halted, bus.timeout};
    return o;
  endfunction

  function automatic void add(input logic [5:0] op, input logic rdy, input outv_t e);
    vec_t v;
    v.op = op; v.rdy = rdy; v.exp = e;
    stim.push_back(v);
  endfunction

  // One full instruction with an immediately ready fetch.
  function automatic void add_instr(input logic [5:0] op, input logic mem_rdy,
                                    input logic [7:0] mem_f, input logic [7:0] wb_f);
    add(op, 1'b1, ev(3'd1, F_MR | F_IR));
    add(op, 1'b1, ev(3'd2, 8'h00));
    add(op, 1'b1, ev(3'd3, 8'h00));
    add(op, mem_rdy, ev(3'd4, mem_f));
    add(op, 1'b1, ev(3'd5, wb_f));
  endfunction

  // Drive one cycle of stimulus, queue its expectation, observe at the falling edge.
  task automatic step(input vec_t v, output outv_t g, output outv_t w);
    bus.opcode    = v.op;
    bus.mem_ready = v.rdy;
    sb.push_back(v.exp);
    @(negedge clk);
    g = sample();
    w = (sb.size() > 0) ? sb.pop_front() : '1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b1;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b1;
    #12;
    got = sample();
    vectors++;
    if (got !== ev(3'd0, 8'h00)) begin
      miscompares++;
      $display("FAIL reset_hold: got state=%0d flags=%b, expected state=0 flags=00000000",
               got.st, got[7:0]);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    add(6'h00, 1'b1, ev(3'd0, 8'h00));
    add_instr(6'h00, 1'b1, 8'h00, F_PC | F_RF);
    add(6'h00, 1'b1, ev(3'd1, F_MR | F_IR));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL rtype[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
  endtask

  task automatic test_lw_wait();
    do_reset();
    add(6'h23, 1'b1, ev(3'd0, 8'h00));
    add(6'h23, 1'b1, ev(3'd1, F_MR | F_IR));
    add(6'h23, 1'b0, ev(3'd2, 8'h00));
    add(6'h23, 1'b0, ev(3'd3, 8'h00));
    for (int k = 0; k < 3; k++) add(6'h23, 1'b0, ev(3'd4, F_MR));
    add(6'h23, 1'b1, ev(3'd4, F_MR));
    add(6'h23, 1'b1, ev(3'd5, F_PC | F_RF));
    add(6'h23, 1'b1, ev(3'd1, F_MR | F_IR));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL lw_wait[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
  endtask

  task automatic test_push();
    do_reset();
    add(6'h1b, 1'b1, ev(3'd0, 8'h00));
    add_instr(6'h1b, 1'b1, F_MW | F_SP, F_PC);
    add(6'h1b, 1'b1, ev(3'd1, F_MR | F_IR));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL push[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
  endtask

  task automatic test_back_to_back();
    do_reset();
    add(6'h2b, 1'b1, ev(3'd0, 8'h00));
    add(6'h2b, 1'b0, ev(3'd1, F_MR));
    add(6'h2b, 1'b1, ev(3'd1, F_MR | F_IR));
    add(6'h2b, 1'b1, ev(3'd2, 8'h00));
    add(6'h2b, 1'b1, ev(3'd3, 8'h00));
    add(6'h2b, 1'b1, ev(3'd4, F_MW));
    add(6'h2b, 1'b1, ev(3'd5, F_PC));
    add_instr(6'h1c, 1'b1, F_MR | F_SP, F_PC | F_RF);
    add_instr(6'h08, 1'b0, 8'h00, F_PC | F_RF);
    add_instr(6'h03, 1'b1, 8'h00, F_PC | F_RF);
    add_instr(6'h05, 1'b0, 8'h00, F_PC);
    add(6'h00, 1'b1, ev(3'd1, F_MR | F_IR));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
  endtask

  task automatic test_timeout();
    do_reset();
    add(6'h00, 1'b0, ev(3'd0, 8'h00));
    for (int k = 0; k < 16; k++) add(6'h00, 1'b0, ev(3'd1, F_MR));
    for (int k = 0; k < 3; k++)  add(6'h00, 1'b1, ev(3'd7, F_HL | F_TO));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
    do_reset();
    add(6'h00, 1'b0, ev(3'd0, 8'h00));
    for (int k = 0; k < 15; k++) add(6'h00, 1'b0, ev(3'd1, F_MR));
    add(6'h00, 1'b1, ev(3'd1, F_MR | F_IR));
    add(6'h00, 1'b1, ev(3'd2, 8'h00));
    add(6'h00, 1'b1, ev(3'd3, 8'h00));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL timeout_last_ready[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
  endtask

  task automatic test_halt();
    do_reset();
    add(6'h3f, 1'b1, ev(3'd0, 8'h00));
    add(6'h3f, 1'b1, ev(3'd1, F_MR | F_IR));
    add(6'h3f, 1'b1, ev(3'd2, 8'h00));
    for (int k = 0; k < 20; k++) add(6'h1b, k[0], ev(3'd6, F_HL));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL halt[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
    rst_n = 1'b0;
    #2;
    got = sample();
    vectors++;
    if (got !== ev(3'd0, 8'h00)) begin
      miscompares++;
      $display("FAIL halt_async_reset: got state=%0d flags=%b, expected state=0 flags=00000000",
               got.st, got[7:0]);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    add(6'h2b, 1'b1, ev(3'd0, 8'h00));
    add(6'h2b, 1'b1, ev(3'd1, F_MR | F_IR));
    add(6'h2b, 1'b1, ev(3'd2, 8'h00));
    add(6'h2b, 1'b0, ev(3'd3, 8'h00));
    add(6'h2b, 1'b0, ev(3'd4, F_MW));
    add(6'h2b, 1'b0, ev(3'd4, F_MW));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL mid_mem[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
    got = sample();
    vectors++;
    if (got !== ev(3'd4, F_MW)) begin
      miscompares++;
      $display("FAIL mid_mem_pre_reset: got state=%0d flags=%b, expected state=4 flags=00000100",
               got.st, got[7:0]);
    end
    rst_n = 1'b0;
    #1;
    got = sample();
    vectors++;
    if (got !== ev(3'd0, 8'h00)) begin
      miscompares++;
      $display("FAIL mid_mem_async_reset: got state=%0d flags=%b, expected state=0 flags=00000000",
               got.st, got[7:0]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add(6'h00, 1'b1, ev(3'd0, 8'h00));
    add(6'h00, 1'b1, ev(3'd1, F_MR | F_IR));
    add(6'h00, 1'b1, ev(3'd2, 8'h00));
    foreach (stim[i]) begin
      step(stim[i], got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL mid_mem_restart[%0d]: got state=%0d flags=%b, expected state=%0d flags=%b",
                 i, got.st, got[7:0], want.st, want[7:0]);
      end
    end
    stim.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_push();
    test_back_to_back();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
